// File: rtl/multiplier_check_seq.sv
// Sequential shift-add multiplier that checks whether a*b is a nontrivial factorization of target.
// Optional early termination when the partial product exceeds target: define MULT_CHECK_EARLY_EXIT_EN.
module multiplier_check_seq #(
    parameter int unsigned A_W = 8,
    parameter int unsigned B_W = 5,
    parameter int unsigned P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [P_W-1:0] target,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sat,
    output logic [P_W-1:0] product,
    output logic           aborted
);

    localparam int unsigned CNT_W = $clog2(B_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [P_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic [P_W-1:0] tgt_q, tgt_d;
    logic [P_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           a_nt_q, a_nt_d;
    logic           b_nt_q, b_nt_d;
    logic           sat_q, sat_d;
    logic [P_W-1:0] product_q, product_d;
    logic           aborted_q, aborted_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           early_exit_c;

    // Accumulator only grows, so once it passes target a match is impossible.
`ifdef MULT_CHECK_EARLY_EXIT_EN
    assign early_exit_c = (acc_q > tgt_q);
`else
    assign early_exit_c = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            tgt_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            a_nt_q      <= 1'b0;
            b_nt_q      <= 1'b0;
            sat_q       <= 1'b0;
            product_q   <= '0;
            aborted_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tgt_q       <= tgt_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            a_nt_q      <= a_nt_d;
            b_nt_q      <= b_nt_d;
            sat_q       <= sat_d;
            product_q   <= product_d;
            aborted_q   <= aborted_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        tgt_d     = tgt_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        a_nt_d    = a_nt_q;
        b_nt_d    = b_nt_q;
        sat_d     = sat_q;
        product_d = product_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = P_W'(a);
                    b_d       = b;
                    tgt_d     = target;
                    acc_d     = '0;
                    cnt_d     = '0;
                    a_nt_d    = (a >= A_W'(2));
                    b_nt_d    = (b >= B_W'(2));
                    sat_d     = 1'b0;
                    product_d = '0;
                    aborted_d = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (early_exit_c) begin
                    product_d = acc_q;
                    sat_d     = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(B_W)) begin
                    // All bits of b consumed; register the result.
                    product_d = acc_q;
                    sat_d     = (acc_q == tgt_q) && a_nt_q && b_nt_q;
                    aborted_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;
    assign product   = product_q;
    assign aborted   = aborted_q;

endmodule
